// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, state encoding and divide-by-zero constants for seq_divider
package div_pkg;

    localparam int DEFAULT_DIVIDEND_W = 8;
    localparam int DEFAULT_DIVISOR_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] DBZ_QUOT = 8'hFF;
    localparam logic [5:0] DBZ_REM  = 6'h3F;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring step: compare partial remainder with divisor, subtract if it fits
module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DEFAULT_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   p_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   p_out,
    output logic                 qbit
);

    logic [DIVISOR_W:0] divisor_ext;

    assign divisor_ext = {1'b0, divisor};
    assign qbit        = (p_in >= divisor_ext);
    assign p_out       = qbit ? (p_in - divisor_ext) : p_in;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEFAULT_DIVIDEND_W,
    parameter int DIVISOR_W  = DEFAULT_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    localparam int              CNT_W   = $clog2(DIVIDEND_W);
    localparam int              PW      = DIVISOR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVIDEND_W - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]         prem_q, prem_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] qacc_q, qacc_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [PW-1:0]         step_in, step_out;
    logic                  step_qbit;

    // Bring the next dividend bit (MSB first) into the partial remainder.
    assign step_in = {prem_q[DIVISOR_W-1:0], dvd_q[cnt_q]};

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .p_in    (step_in),
        .divisor (dvs_q),
        .p_out   (step_out),
        .qbit    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qacc_d  = qacc_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = DIVIDEND_W'(DBZ_QUOT);
                        rem_d   = DIVISOR_W'(DBZ_REM);
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        prem_d  = '0;
                        qacc_d  = '0;
                        cnt_d   = CNT_MAX;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = step_out;
                qacc_d = {qacc_q[DIVIDEND_W-2:0], step_qbit};
                if (cnt_q == '0) begin
                    quot_d  = {qacc_q[DIVIDEND_W-2:0], step_qbit};
                    rem_d   = step_out[DIVISOR_W-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qacc_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qacc_q  <= qacc_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign dbz       = dbz_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider: directed vectors plus a partial sweep
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [5:0] divisor;
    logic       busy;
    logic       done;
    logic       dbz;
    logic [7:0] quotient;
    logic [5:0] remainder;

    typedef struct {
        logic [7:0] a;
        logic [5:0] b;
        logic [7:0] q;
        logic [5:0] r;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops one expectation for every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk(!(busy && done), "busy_done_exclusive", int'(busy & done), 0);
            if (done) begin
                chk(exp_q.size() != 0, "unexpected_done", 1, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(quotient == e.q, $sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
                    chk(remainder == e.r, $sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
                    chk(dbz == e.z, $sformatf("dbz %0d/%0d", e.a, e.b), dbz, e.z);
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [5:0] b, input logic [7:0] eq,
                          input logic [5:0] er, input logic ez, input int lat);
        int  n;
        int  bcnt;
        bit  seen;
        exp_q.push_back('{a: a, b: b, q: eq, r: er, z: ez});
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        n = 0; bcnt = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        chk(seen && n == lat, $sformatf("latency %0d/%0d", a, b), n, lat);
        chk(bcnt == (ez ? 0 : 8), $sformatf("busy_cycles %0d/%0d", a, b), bcnt, ez ? 0 : 8);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got 0, required 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dvs_list[8];
        int  dvd_list[6];
        int  f0;
        int  done_edges[$];
        bit  stop;
        dvs_list = '{1, 2, 3, 7, 13, 32, 62, 63};
        dvd_list = '{0, 1, 127, 128, 200, 255};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(done == 1'b0, "reset_done", done, 0);
        chk(dbz == 1'b0, "reset_dbz", dbz, 0);
        chk(quotient == 8'd0, "reset_quotient", quotient, 0);
        chk(remainder == 6'd0, "reset_remainder", remainder, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd200, 6'd7, 8'd28, 6'd4, 1'b0, 9);
        run_op(8'd255, 6'd1, 8'd255, 6'd0, 1'b0, 9);
        run_op(8'd5, 6'd63, 8'd0, 6'd5, 1'b0, 9);
        run_op(8'd0, 6'd9, 8'd0, 6'd0, 1'b0, 9);
        run_op(8'd100, 6'd0, 8'hFF, 6'h3F, 1'b1, 1);
        run_op(8'd10, 6'd3, 8'd3, 6'd1, 1'b0, 9);

        // start held high: three back-to-back divisions, operands disturbed mid-CALC
        repeat (3) exp_q.push_back('{a: 8'd50, b: 6'd5, q: 8'd10, r: 6'd0, z: 1'b0});
        @(negedge clk);
        dividend = 8'd50; divisor = 6'd5; start = 1'b1;
        for (int e = 1; e <= 40 && done_edges.size() < 3; e++) begin
            @(posedge clk);
            #1;
            if ((e - 1) % 10 == 3) begin dividend = 8'd99; divisor = 6'd7; end
            if ((e - 1) % 10 == 6) begin dividend = 8'd50; divisor = 6'd5; end
            if (done) done_edges.push_back(e);
        end
        start = 1'b0;
        chk(done_edges.size() == 3, "b2b_count", done_edges.size(), 3);
        for (int i = 0; i < done_edges.size(); i++)
            chk(done_edges[i] == 9 + 10 * i, "b2b_done_edge", done_edges[i], 9 + 10 * i);
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset in the middle of 77/6
        @(negedge clk);
        dividend = 8'd77; divisor = 6'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(busy == 1'b1, "midcalc_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk(busy == 1'b0, "abort_busy", busy, 0);
        chk(done == 1'b0, "abort_done", done, 0);
        chk(dbz == 1'b0, "abort_dbz", dbz, 0);
        chk(quotient == 8'd0, "abort_quotient", quotient, 0);
        chk(remainder == 6'd0, "abort_remainder", remainder, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        run_op(8'd77, 6'd6, 8'd12, 6'd5, 1'b0, 9);

        // sweep: all dividends for selected divisors, all divisors for selected dividends
        stop = 0;
        for (int i = 0; i < 8 && !stop; i++) begin
            for (int a = 0; a < 256 && !stop; a++) begin
                f0 = n_fail;
                run_op(8'(a), 6'(dvs_list[i]), 8'(a / dvs_list[i]), 6'(a % dvs_list[i]), 1'b0, 9);
                if (n_fail != f0) stop = 1;
            end
        end
        for (int i = 0; i < 6 && !stop; i++) begin
            for (int b = 1; b < 64 && !stop; b++) begin
                f0 = n_fail;
                run_op(8'(dvd_list[i]), 6'(b), 8'(dvd_list[i] / b), 6'(dvd_list[i] % b), 1'b0, 9);
                if (n_fail != f0) stop = 1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
